// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display request scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package disp_sched_pkg;

    localparam int N_REQ  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot16(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_sel16.sv
// Picks the first set bit of vec searching downward from start, wrapping 0 -> 15.
// Latency: purely combinational.
// Backpressure: none; valid is low when vec is empty (idx is then 0).
module prio_sel16
    import disp_sched_pkg::*;
(
    input  logic [N_REQ-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic              valid,
    output logic [CODE_W-1:0] idx
);

    logic [CODE_W-1:0] cand;

    // Scan from the farthest candidate toward start so the nearest hit is assigned last.
    always_comb begin
        valid = |vec;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = start - CODE_W'(k);
            if (vec[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/disp_req_sched.sv
// Time-shares one code/blank display path among 16 active-low requesters; optional
// round-robin arbitration when DISP_REQ_SCHED_RR_EN is defined (fixed priority otherwise).
// Latency: request to PEND 3 cycles; a service is DWELL_CYC shown + GAP_CYC blanked + 1 idle.
// Backpressure: none on requests (they are queued in PEND); EI high aborts a service without ACK.
module disp_req_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL_CYC = 1000,
    parameter int GAP_CYC   = 100,
    parameter int CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EI,
    input  logic [N_REQ-1:0]    REQ_N,
    output logic [CODE_W-1:0]   CODE,
    output logic                BI,
    output logic [N_REQ-1:0]    ACK,
    output logic                BUSY,
    output logic [N_REQ-1:0]    PEND
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    logic [N_REQ-1:0]  req_s1, req_s2;
    logic              ei_s1, ei_s2;
    logic [N_REQ-1:0]  pend_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [N_REQ-1:0]  ack_q;
    logic              retire;
    logic [N_REQ-1:0]  clr;
    logic              pick_vld;
    logic [CODE_W-1:0] pick_idx;
    logic [CODE_W-1:0] pick_start;

    // Two-flop synchronisers; idle level is all-ones (no request, scheduler halted).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_s1 <= '1;
            req_s2 <= '1;
            ei_s1  <= 1'b1;
            ei_s2  <= 1'b1;
        end else begin
            req_s1 <= REQ_N;
            req_s2 <= req_s1;
            ei_s1  <= EI;
            ei_s2  <= ei_s1;
        end
    end

    // Pending set: a still-held request re-sets its bit in the same cycle it is retired.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr) | ~req_s2;
        end
    end

`ifdef DISP_REQ_SCHED_RR_EN
    logic [CODE_W-1:0] last_served;

    // Remember the last retired index; aborts leave it untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_served <= '0;
        end else if (retire) begin
            last_served <= code_q;
        end
    end

    assign pick_start = last_served - CODE_W'(1);
`else
    assign pick_start = CODE_W'(N_REQ - 1);
`endif

    prio_sel16 u_prio (
        .vec   (pend_q),
        .start (pick_start),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Next-state logic; the counter is loaded only on entry to SHOW or GAP, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ei_s2 && pick_vld) begin
                    state_d = SHOW;
                    code_d  = pick_idx;
                    cnt_d   = DWELL_LD;
                end
            end
            SHOW: begin
                if (ei_s2) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (GAP_CYC == 0) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (ei_s2) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr = retire ? onehot16(code_q) : '0;

    // State, counter, selected code and the registered ACK pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ack_q   <= clr;
        end
    end

    assign CODE = code_q;
    assign BI   = (state_q == SHOW);
    assign BUSY = (state_q != IDLE);
    assign ACK  = ack_q;
    assign PEND = pend_q;

endmodule

// File: tb/tb_disp_req_sched.sv
// Bench for disp_req_sched: two instances (with and without a gap period) share stimulus
// and are compared each cycle against a time-since-service-start reference model;
// ACK pulses are also checked through per-instance scoreboards.
module tb_disp_req_sched;

    localparam int DW0 = 4;
    localparam int GP0 = 2;
    localparam int DW1 = 3;
    localparam int GP1 = 0;

    logic        CLK;
    logic        RST;
    logic        EI;
    logic [15:0] REQ_N;

    logic [3:0]  code_o [2];
    logic        bi_o   [2];
    logic        busy_o [2];
    logic [15:0] ack_o  [2];
    logic [15:0] pend_o [2];

    disp_req_sched #(.DWELL_CYC(DW0), .GAP_CYC(GP0), .CNT_W(8)) u_dut0 (
        .CLK(CLK), .RST(RST), .EI(EI), .REQ_N(REQ_N),
        .CODE(code_o[0]), .BI(bi_o[0]), .ACK(ack_o[0]), .BUSY(busy_o[0]), .PEND(pend_o[0])
    );

    disp_req_sched #(.DWELL_CYC(DW1), .GAP_CYC(GP1), .CNT_W(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .EI(EI), .REQ_N(REQ_N),
        .CODE(code_o[1]), .BI(bi_o[1]), .ACK(ack_o[1]), .BUSY(busy_o[1]), .PEND(pend_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          dwv [2] = '{DW0, DW1};
    int          gpv [2] = '{GP0, GP1};
    logic [15:0] h1 = '1, h2 = '1;
    logic        e1 = 1'b1, e2 = 1'b1;
    logic [15:0] m_pend [2] = '{16'h0, 16'h0};
    bit          m_on   [2] = '{1'b0, 1'b0};
    int          m_t    [2] = '{0, 0};
    logic [3:0]  m_code [2] = '{4'h0, 4'h0};
    logic [3:0]  m_last [2] = '{4'h0, 4'h0};
    logic [15:0] m_ack  [2] = '{16'h0, 16'h0};
    logic [15:0] m_clr;
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int          seen0 [$];

    function automatic logic [3:0] pick(input logic [15:0] p, input logic [3:0] last);
`ifdef DISP_REQ_SCHED_RR_EN
        for (int k = 1; k <= 16; k++) begin
            int i;
            i = (int'(last) - k + 32) % 16;
            if (p[i]) return 4'(i);
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (p[i]) return 4'(i);
        end
`endif
        return 4'd0;
    endfunction

    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                h1 = '1; h2 = '1; e1 = 1'b1; e2 = 1'b1;
                for (int n = 0; n < 2; n++) begin
                    m_pend[n] = '0; m_on[n] = 1'b0; m_t[n] = 0;
                    m_code[n] = '0; m_last[n] = '0; m_ack[n] = '0;
                end
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                for (int n = 0; n < 2; n++) begin
                    m_clr    = '0;
                    m_ack[n] = '0;
                    if (m_on[n]) begin
                        if (e2) begin
                            m_on[n] = 1'b0;
                        end else if (m_t[n] == dwv[n] + gpv[n] - 1) begin
                            m_clr     = 16'd1 << m_code[n];
                            m_ack[n]  = m_clr;
                            m_on[n]   = 1'b0;
                            m_last[n] = m_code[n];
                            if (n == 0) exp_q0.push_back(m_clr);
                            else        exp_q1.push_back(m_clr);
                        end else begin
                            m_t[n]++;
                        end
                    end else if (!e2 && m_pend[n] != 0) begin
                        m_code[n] = pick(m_pend[n], m_last[n]);
                        m_on[n]   = 1'b1;
                        m_t[n]    = 0;
                    end
                    m_pend[n] = (m_pend[n] & ~m_clr) | ~h2;
                end
                h2 = h1; h1 = REQ_N;
                e2 = e1; e1 = EI;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("bi%0d", n),   bi_o[n],   (m_on[n] && m_t[n] < dwv[n]));
                    chk($sformatf("busy%0d", n), busy_o[n], m_on[n]);
                    chk($sformatf("code%0d", n), code_o[n], m_code[n]);
                    chk($sformatf("pend%0d", n), pend_o[n], m_pend[n]);
                    chk($sformatf("ack%0d", n),  ack_o[n],  m_ack[n]);
                end
                if (ack_o[0] != 0) begin
                    for (int i = 0; i < 16; i++) if (ack_o[0][i]) seen0.push_back(i);
                    if (exp_q0.size() == 0) chk("sb_ack0_unexpected", ack_o[0], 0);
                    else                    chk("sb_ack0", ack_o[0], exp_q0.pop_front());
                end
                if (ack_o[1] != 0) begin
                    if (exp_q1.size() == 0) chk("sb_ack1_unexpected", ack_o[1], 0);
                    else                    chk("sb_ack1", ack_o[1], exp_q1.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int budget);
        int k;
        repeat (4) @(negedge CLK);
        for (k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (!busy_o[0] && !busy_o[1] && pend_o[0] == 0 && pend_o[1] == 0) break;
        end
        chk("idle_timeout", (k < budget), 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_show(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (bi_o[0]) break;
        end
        chk("show_timeout", (k < budget), 1);
    endtask

    initial begin
        int k;
        REQ_N = '1;
        EI    = 1'b0;
        RST   = 1'b1;
        repeat (3) @(negedge CLK);
        for (int n = 0; n < 2; n++) begin
            chk("rst_code", code_o[n], 0);
            chk("rst_bi",   bi_o[n],   0);
            chk("rst_busy", busy_o[n], 0);
            chk("rst_ack",  ack_o[n],  0);
            chk("rst_pend", pend_o[n], 0);
        end
        RST = 1'b0;

        // Priority: 3 and 12 together, 12 served first.
        seen0.delete();
        REQ_N[3] = 1'b0; REQ_N[12] = 1'b0;
        repeat (5) @(negedge CLK);
        REQ_N = '1;
        wait_idle(80);
        chk("prio_count", seen0.size(), 2);
        if (seen0.size() == 2) begin
            chk("prio_first",  seen0[0], 12);
            chk("prio_second", seen0[1], 3);
        end

        // Held request re-queues.
        REQ_N[7] = 1'b0;
        repeat (40) @(negedge CLK);
        chk("setwins_pend7", pend_o[0][7], 1);
        REQ_N = '1;
        wait_idle(80);

        // Abort in second SHOW cycle of code 9.
        seen0.delete();
        REQ_N[9] = 1'b0;
        repeat (2) @(negedge CLK);
        REQ_N = '1;
        wait_show(40);
        @(negedge CLK);
        EI = 1'b1;
        repeat (5) @(negedge CLK);
        chk("abort_bi",    bi_o[0],      0);
        chk("abort_busy",  busy_o[0],    0);
        chk("abort_pend9", pend_o[0][9], 1);
        chk("abort_noack", seen0.size(), 0);
        EI = 1'b0;
        wait_idle(80);
        chk("abort_reserve_count", seen0.size(), 1);
        if (seen0.size() == 1) chk("abort_reserve_code", seen0[0], 9);

        // Reset in the middle of SHOW with request 5 held.
        REQ_N[5] = 1'b0;
        wait_show(40);
        #2 RST = 1'b1;
        #1;
        chk("amid_code", code_o[0], 0);
        chk("amid_bi",   bi_o[0],   0);
        chk("amid_busy", busy_o[0], 0);
        chk("amid_pend", pend_o[0], 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("amid_pend5_early", pend_o[0][5], 0);
        @(negedge CLK);
        chk("amid_pend5_back", pend_o[0][5], 1);
        REQ_N = '1;
        wait_idle(80);

        // 15 and 14 held: alternate under round-robin, 15 only otherwise.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        seen0.delete();
        REQ_N[15] = 1'b0; REQ_N[14] = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (seen0.size() >= 3) break;
        end
        chk("order_timeout", (k < 200), 1);
        if (seen0.size() >= 3) begin
            chk("order_0", seen0[0], 15);
`ifdef DISP_REQ_SCHED_RR_EN
            chk("order_1", seen0[1], 14);
`else
            chk("order_1", seen0[1], 15);
`endif
            chk("order_2", seen0[2], 15);
        end
        REQ_N = '1;
        wait_idle(120);

        // Randomised traffic with occasional EI pulses.
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] r;
            r     = $urandom & $urandom & $urandom;
            REQ_N = ~r[15:0];
            EI    = ($urandom_range(0, 29) == 0);
            @(negedge CLK);
        end
        REQ_N = '1;
        EI    = 1'b0;
        wait_idle(400);
        chk("sb0_drained", exp_q0.size(), 0);
        chk("sb1_drained", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/disp_req_sched.md
Name: disp_req_sched

Overview:
- Sequencer that shares one 16-to-4 priority encoder and 7-segment decoder display path between 16 active-low requesters.
- Captures and queues requests, selects the highest-priority pending one, and drives its 4-bit code plus the active-low blanking line to the display decoder for a fixed dwell time.
- After the dwell time it blanks for a gap period, acknowledges the served requester, then moves to the next pending request.
- Sits between the raw switch/request inputs and the display decoder (BI/A inputs) in the lab top level.

Parameters:
- DWELL_CYC, 1000, clock cycles a selected code is shown (must be >= 1)
- GAP_CYC, 100, clock cycles the display is blanked between codes (0 means no gap state)
- CNT_W, 16, width of the shared dwell/gap counter; must satisfy 2^CNT_W > max(DWELL_CYC, GAP_CYC)

Ports:
- CLK, input, 1, system clock, rising edge
- RST, input, 1, asynchronous active-high reset
- EI, input, 1, active-low enable; 1 = scheduler halted
- REQ_N, input, 16, active-low requests; bit 15 has highest priority; bits 15..8 form the upper byte group, bits 7..0 the lower
- CODE, output, 4, index of the served request, to decoder A[3:0]
- BI, output, 1, active-low blank to decoder; 0 = display dark
- ACK, output, 16, one-hot, one-cycle pulse when a request is retired
- BUSY, output, 1, 1 while in SHOW or GAP
- PEND, output, 16, current pending-request vector (debug)

Behaviour:
- Reset (asynchronous, any time, including mid-SHOW): CODE=0, BI=0, ACK=0, BUSY=0, PEND=0, state=IDLE, counter=0, synchroniser flops=all-ones (inactive).
- Input sync: REQ_N and EI pass through 2-FF synchronisers. Request-to-PEND latency is 3 cycles.
- Pending: each cycle, PEND[i] <= (PEND[i] & ~clr[i]) | ~req_sync[i]. On a simultaneous set and clear of the same bit, set wins, so a held request re-queues.
- Priority: fixed; the highest set index of PEND wins.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - BI=0, BUSY=0.
  - If ei_sync=0 and PEND!=0: latch sel=highest index, CODE<=sel, counter<=DWELL_CYC-1, go to SHOW.
- SHOW:
  - BI=1, BUSY=1. Counter decrements each cycle. CODE stays stable for exactly DWELL_CYC cycles.
  - At counter=0: if GAP_CYC=0, retire and go to IDLE; else counter<=GAP_CYC-1 and go to GAP.
- GAP:
  - BI=0, BUSY=1, CODE holds. Counter decrements.
  - At counter=0: retire and go to IDLE.
- Retire: ACK[sel] pulses high for 1 cycle and PEND[sel] is cleared in the same cycle, subject to set-wins.
- Back-to-back requests: IDLE lasts at least 1 cycle between services. The next service's SHOW starts 1 cycle after retirement.
- EI deasserted (ei_sync=1) in SHOW or GAP:
  - Abort to IDLE next cycle with BI=0.
  - No ACK is issued; PEND[sel] is retained and re-arbitrated once EI returns low.
- A request arriving during SHOW or GAP is only queued. It does not pre-empt, even if it has higher priority.
- The counter never wraps: each load happens only on a state entry.
- BUSY=0 and BI=0 whenever the state is IDLE.

Optional Feature:
- Macro: DISP_REQ_SCHED_RR_EN.
- Defined:
  - Round-robin priority. The search starts at index (last_served-1) mod 16 and descends with wrap-around.
  - last_served resets to 0, so the first search starts at index 15.
  - last_served updates on ACK only; an abort does not update it.
- Undefined:
  - Fixed priority, highest index wins.
  - No last_served register is synthesised.

Decomposition:
- Shared package disp_sched_pkg:
  - state enum {IDLE, SHOW, GAP}
  - constants N_REQ=16 and CODE_W=4
  - function onehot16(idx)
- One sub-module, prio_sel16 (combinational):
  - Inputs: vec[15:0], start[3:0].
  - Outputs: valid, idx[3:0] = first set bit descending from start with wrap.
  - Fixed priority uses start=15.

Test Plan:
- Reset mid-SHOW: hold REQ_N[5]=0, then assert RST for 1 cycle while in SHOW -> all outputs 0 asynchronously; after RST release, PEND[5] reasserts 3 cycles later.
- Priority: DWELL_CYC=4, GAP_CYC=2; REQ_N[3] and REQ_N[12] pulsed low together for 5 cycles -> CODE=12 with BI=1 for 4 cycles, then BI=0 for 2, ACK=0x1000; then CODE=3, then ACK=0x0008.
- Set-wins: hold REQ_N[7]=0 continuously -> CODE=7 is served repeatedly, with ACK[7] pulsing every DWELL+GAP+1 cycles and PEND[7] never dropping.
- Abort: EI driven high in cycle 2 of SHOW serving code 9 -> BI=0 and BUSY=0 after the sync latency, no ACK, PEND[9]=1; EI low again -> code 9 is served in full and ACK=0x0200.
- GAP_CYC=0: single request 0 -> BI high exactly DWELL_CYC cycles, then direct retire with ACK=0x0001 and no blank state.
- RR_EN build: REQ_N[15] and REQ_N[14] held low -> service order 15, 14, 15, 14 (alternating); in the non-RR build the order is 15, 15, 15.
